// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: request ports P and D plus the memory side
// slave = arbiter view, master = requester/memory view
interface dmem_arbiter_if #(
  parameter int IDX_W = 10
);
  logic             p_req;
  logic             p_we;
  logic [63:0]      p_addr;
  logic [63:0]      p_wdata;
  logic [63:0]      p_rdata;
  logic             p_done;
  logic             p_err;
  logic             p_stall;
  logic             d_req;
  logic             d_we;
  logic [63:0]      d_addr;
  logic [63:0]      d_wdata;
  logic [63:0]      d_rdata;
  logic             d_done;
  logic             d_err;
  logic             m_en;
  logic             m_we;
  logic [IDX_W-1:0] m_idx;
  logic [63:0]      m_wdata;
  logic [63:0]      m_rdata;
  logic             m_ack;

  modport slave (
    input  p_req, p_we, p_addr, p_wdata,
    output p_rdata, p_done, p_err, p_stall,
    input  d_req, d_we, d_addr, d_wdata,
    output d_rdata, d_done, d_err,
    output m_en, m_we, m_idx, m_wdata,
    input  m_rdata, m_ack
  );

  modport master (
    output p_req, p_we, p_addr, p_wdata,
    input  p_rdata, p_done, p_err, p_stall,
    output d_req, d_we, d_addr, d_wdata,
    input  d_rdata, d_done, d_err,
    input  m_en, m_we, m_idx, m_wdata,
    output m_rdata, m_ack
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the 64-bit data memory between MEM stage (P) and loader (D)
// DMEM_ARB_RR_EN selects round-robin instead of fixed P priority
module dmem_arbiter #(
  parameter int DEPTH   = 1024,
  parameter int IDX_W   = 10,
  parameter int TIMEOUT = 16
) (
  input  logic          clock,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, DONE
  } state_t;

  typedef enum logic {
    OWN_P, OWN_D
  } own_t;

  state_t       state;
  own_t         owner;
  own_t         last_owner;
  logic [CW-1:0] cnt;
  logic         grant_d;
  logic         sel_we;
  logic [63:0]  sel_addr;
  logic [63:0]  sel_wdata;
  logic         bad;

`ifdef DMEM_ARB_RR_EN
  assign grant_d = bus.d_req &
    (~bus.p_req | (last_owner == OWN_P));
`else
  logic unused_last;
  assign unused_last = last_owner;
  assign grant_d = bus.d_req & ~bus.p_req;
`endif

  assign sel_we    = grant_d ? bus.d_we    : bus.p_we;
  assign sel_addr  = grant_d ? bus.d_addr  : bus.p_addr;
  assign sel_wdata = grant_d ? bus.d_wdata : bus.p_wdata;

  assign bad = (sel_addr[2:0] != 3'b000) |
    (sel_addr[63:3] >= 61'(DEPTH));

  assign bus.p_stall = bus.p_req & ~bus.p_done;

  // access sequencer: IDLE -> ISSUE -> WAIT -> DONE, all outputs registered
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      owner       <= OWN_P;
      last_owner  <= OWN_D;
      cnt         <= '0;
      bus.m_en    <= 1'b0;
      bus.m_we    <= 1'b0;
      bus.m_idx   <= '0;
      bus.m_wdata <= '0;
      bus.p_rdata <= '0;
      bus.p_done  <= 1'b0;
      bus.p_err   <= 1'b0;
      bus.d_rdata <= '0;
      bus.d_done  <= 1'b0;
      bus.d_err   <= 1'b0;
    end else begin
      bus.m_en   <= 1'b0;
      bus.p_done <= 1'b0;
      bus.p_err  <= 1'b0;
      bus.d_done <= 1'b0;
      bus.d_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.p_req | bus.d_req) begin
            owner       <= grant_d ? OWN_D : OWN_P;
            bus.m_we    <= sel_we;
            bus.m_idx   <= sel_addr[IDX_W+2:3];
            bus.m_wdata <= sel_wdata;
            if (bad) begin
              state      <= DONE;
              bus.p_done <= ~grant_d;
              bus.p_err  <= ~grant_d;
              bus.d_done <= grant_d;
              bus.d_err  <= grant_d;
            end else begin
              state    <= ISSUE;
              bus.m_en <= 1'b1;
            end
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (bus.m_ack) begin
            state      <= DONE;
            bus.p_done <= (owner == OWN_P);
            bus.d_done <= (owner == OWN_D);
            if (!bus.m_we) begin
              if (owner == OWN_D)
                bus.d_rdata <= bus.m_rdata;
              else
                bus.p_rdata <= bus.m_rdata;
            end
          end else begin
            cnt <= cnt + 1'b1;
            if (TIMEOUT != 0 && cnt == TO_LAST) begin
              state      <= DONE;
              bus.p_done <= (owner == OWN_P);
              bus.p_err  <= (owner == OWN_P);
              bus.d_done <= (owner == OWN_D);
              bus.d_err  <= (owner == OWN_D);
            end
          end
        end
        DONE: begin
          last_owner <= owner;
          state      <= IDLE;
        end
      endcase
    end
  end
endmodule
